sobol_rng_lsz_gen: RTL
======================

Name: sobol_rng_lsz_gen

Overview:
- Parametrised Sobol sequence generator for the stochastic-computing RNG path.
- Keeps an internal index counter and finds the least-significant-zero (LSZ) index of it, at any width.
- Each accepted step XORs the selected direction vector into the output.
- Direction vectors load at run time, so one block serves any Sobol dimension. It feeds the comparators of the uMUL/gMUL stochastic units.

Parameters:
WIDTH, 8, bit width of counter, direction vectors and random output (legal 2..16)
LOGWIDTH, $clog2(WIDTH), width of LSZ index and DV write address

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  synchronous active-high reset
dv_we  input  1  direction-vector write strobe
dv_addr  input  LOGWIDTH  DV entry to write (0..WIDTH-1)
dv_data  input  WIDTH  DV value
start  input  1  leave LOAD, enter RUN
stop  input  1  return to LOAD from RUN
rng_ready  input  1  consumer takes rng_out this cycle
rng_valid  output  1  rng_out holds a valid sample
rng_out  output  WIDTH  current Sobol sample
lsz_idx  output  LOGWIDTH  LSZ index of current counter value
wrap  output  1  one-cycle pulse when the sequence completes 2^WIDTH samples
busy  output  1  high in RUN

Behaviour:
- Reset (rst=1 at posedge):
  - state=LOAD; counter=0; rng_out=0; rng_valid=0; wrap=0; busy=0; lsz_idx=0.
  - All DV entries cleared to 0.
  - Reset mid-RUN aborts the sequence immediately; there is no drain.
- LSZ function (combinational, on the counter):
  - inacc[0]=~cnt[0]; inacc[i]=inacc[i-1]|~cnt[i].
  - One-hot: oh[0]=inacc[0]; oh[i]=inacc[i-1]^inacc[i].
  - Encode the one-hot to an index with a generate-based OR-reduction, not a case table, so any WIDTH works.
  - If cnt is all ones, oh=0 and lsz_idx=0; this case is flagged internally as "last".
- State LOAD:
  - dv_we=1 writes dv[dv_addr]<=dv_data. Addresses >=WIDTH are ignored.
  - rng_valid=0, busy=0.
  - start=1 moves to RUN next cycle. Counter and rng_out are re-initialised to 0 on that transition.
- State RUN:
  - busy=1, rng_valid=1.
  - dv_we is ignored; DV contents are frozen.
  - Handshake: a step fires when rng_valid & rng_ready.
  - Step when counter is not last:
    - rng_out <= rng_out ^ dv[lsz_idx]; counter <= counter+1.
    - Latency 1 cycle: the new sample is visible the cycle after the handshake.
  - Step when counter is last (all ones):
    - rng_out<=0; counter<=0; wrap=1 for exactly the next cycle; stay in RUN.
  - rng_ready=0 holds rng_out, counter and lsz_idx stable indefinitely.
- stop=1 in RUN moves to LOAD next cycle; rng_valid drops that same next cycle.
  - If stop coincides with a handshake, the step still commits, then the state leaves.
- start and stop high together in RUN: stop wins. start in RUN and stop in LOAD are ignored.
- lsz_idx is registered-path combinational from the counter: it always reflects the current counter.
- Sample 0 of every sequence is 0. The sequence period is exactly 2^WIDTH handshakes.

Test Plan:
- Reset and hold: assert rst 2 cycles during RUN -> next cycle rng_out=0, rng_valid=0, busy=0, wrap=0, all dv read back as 0 (LOAD then start with dv=0 gives constant 0).
- Van der Corput sequence: WIDTH=4, load dv0=8, dv1=4, dv2=2, dv3=1, start, rng_ready=1 -> rng_out sequence 0,8,12,4,6,14,10,2,3 with lsz_idx 0,1,0,2,0,1,0,3.
- Wrap: WIDTH=4, run 16 handshakes -> on handshake 16 (counter=15) rng_out returns to 0 and wrap pulses high exactly one cycle; the next 16 samples repeat the first 16.
- Backpressure: drop rng_ready for 5 cycles after sample 12 -> rng_out stays 12 and lsz_idx stays 0 for all 5 cycles; resume yields 4.
- Load protection: in RUN, pulse dv_we with addr 0, data 15 -> no effect. Then stop, write it in LOAD, start -> first step yields 15.
- Width sweep: WIDTH=8 and 16 with dv[k]=1<<(WIDTH-1-k) -> the first 2^WIDTH outputs (16 only first 4096 plus a wrap check via forced counter) are a permutation with no repeats; lsz_idx equals the trailing-ones count of the counter every cycle.

Source files
------------

// File: rtl/sobol_rng_lsz_gen_if.sv
// Handshake and direction-vector load bus for the Sobol generator.
//
// Valid/ready: a sample transfers on every rising clk edge where rng_valid
// and rng_ready are both high. The producer holds rng_out stable while
// rng_valid is high and rng_ready is low. The consumer may raise or lower
// rng_ready in any cycle. rng_valid never depends on rng_ready.
interface sobol_rng_lsz_gen_if #(
    parameter int WIDTH    = 8,
    parameter int LOGWIDTH = $clog2(WIDTH)
);
    logic                dv_we;
    logic [LOGWIDTH-1:0] dv_addr;
    logic [WIDTH-1:0]    dv_data;
    logic                start;
    logic                stop;
    logic                rng_ready;
    logic                rng_valid;
    logic [WIDTH-1:0]    rng_out;
    logic [LOGWIDTH-1:0] lsz_idx;
    logic                wrap;
    logic                busy;

    // Consumer / configuration side
    modport master (
        output dv_we, dv_addr, dv_data, start, stop, rng_ready,
        input  rng_valid, rng_out, lsz_idx, wrap, busy
    );

    // Generator side
    modport slave (
        input  dv_we, dv_addr, dv_data, start, stop, rng_ready,
        output rng_valid, rng_out, lsz_idx, wrap, busy
    );
endinterface

// File: rtl/sobol_rng_lsz_gen.sv
// Sobol sequence generator. A counter walks through 2^WIDTH values; on each
// accepted sample the direction vector picked by the least-significant-zero
// position of the counter is XORed into the output. Direction vectors are
// loaded at run time while idle, so one block serves any Sobol dimension.
// The FSM state is visible on busy (LOAD=0, RUN=1).
module sobol_rng_lsz_gen #(
    parameter int WIDTH    = 8,
    parameter int LOGWIDTH = $clog2(WIDTH)
) (
    input logic                clk,
    input logic                rst,
    sobol_rng_lsz_gen_if.slave bus
);
    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]          state;
    logic [WIDTH-1:0]    cnt;
    logic [WIDTH-1:0]    rng_q;
    logic                wrap_q;
    logic [WIDTH-1:0]    dv [WIDTH];

    logic [WIDTH-1:0]    inacc;
    logic [WIDTH-1:0]    oh;
    logic [LOGWIDTH-1:0][WIDTH-1:0] enc_terms;
    logic [LOGWIDTH-1:0] lsz;
    logic                last;
    logic                fire;
    logic                dv_addr_ok;

    // Zero-accumulator chain: inacc[i] is high once any bit at or below i is zero;
    // the first rising position of the chain is the least-significant zero.
    assign inacc[0] = ~cnt[0];
    assign oh[0]    = inacc[0];
    generate
        for (genvar i = 1; i < WIDTH; i++) begin : g_chain
            assign inacc[i] = inacc[i-1] | ~cnt[i];
            assign oh[i]    = inacc[i-1] ^ inacc[i];
        end
    endgenerate

    // One-hot to binary: index bit b is the OR of every one-hot line whose
    // position has bit b set. An all-ones counter gives oh=0 and index 0.
    generate
        for (genvar b = 0; b < LOGWIDTH; b++) begin : g_enc
            for (genvar i = 0; i < WIDTH; i++) begin : g_term
                if (((i >> b) & 1) == 1) begin : g_on
                    assign enc_terms[b][i] = oh[i];
                end else begin : g_off
                    assign enc_terms[b][i] = 1'b0;
                end
            end
            assign lsz[b] = |enc_terms[b];
        end
    endgenerate

    assign last       = &cnt;
    assign fire       = (state == ST_RUN) & bus.rng_ready;
    assign dv_addr_ok = 32'(bus.dv_addr) < WIDTH;

    // Direction-vector table: written only while idle, frozen during a run.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < WIDTH; k++) begin
                dv[k] <= '0;
            end
        end else if (state == ST_LOAD && bus.dv_we && dv_addr_ok) begin
            dv[bus.dv_addr] <= bus.dv_data;
        end
    end

    // Run control, counter and sample update; a step on the last counter
    // value restarts the sequence at 0 and flags wrap for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_LOAD;
            cnt    <= '0;
            rng_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (bus.start) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                        rng_q <= '0;
                    end
                end
                ST_RUN: begin
                    if (fire) begin
                        if (last) begin
                            rng_q  <= '0;
                            cnt    <= '0;
                            wrap_q <= 1'b1;
                        end else begin
                            rng_q <= rng_q ^ dv[lsz];
                            cnt   <= cnt + 1'b1;
                        end
                    end
                    if (bus.stop) begin
                        state <= ST_LOAD;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    assign bus.rng_valid = (state == ST_RUN);
    assign bus.busy      = (state == ST_RUN);
    assign bus.rng_out   = rng_q;
    assign bus.lsz_idx   = lsz;
    assign bus.wrap      = wrap_q;
endmodule
